// File: rtl/gpif_burst_reader_pkg.sv
// Shared definitions for the GPIF burst reader: FSM encoding, burst-length limits and
// the word-counter width helper.
package gpif_burst_reader_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReady = 2'd1,
    StBurst = 2'd2,
    StTurn  = 2'd3
  } gpif_state_e;

  localparam int unsigned BurstWordsMin = 2;
  localparam int unsigned BurstWordsMax = 4096;

  // Counter spans 0..words-1; out-of-range lengths are clamped so the width stays sane.
  function automatic int unsigned cnt_width(input int unsigned words);
    int unsigned w;
    w = words;
    if (w < BurstWordsMin) w = BurstWordsMin;
    if (w > BurstWordsMax) w = BurstWordsMax;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/gpif_burst_reader.sv
// Streams words from an upstream 16-bit FIFO to a GPIF host in bounded bursts,
// padding on underrun and flagging the last word of each burst.
module gpif_burst_reader
  import gpif_burst_reader_pkg::*;
#(
  parameter int unsigned BURST_WORDS = 256,
  parameter logic [15:0] PAD_WORD    = 16'h0000
) (
  input  logic        gpif_clk,
  input  logic        gpif_rst,
  input  logic        clear,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_eof,
  input  logic        in_has_data,
  output logic        in_enable,
  input  logic        gpif_rd,
  output logic        gpif_rdy,
  output logic [15:0] gpif_dout,
  output logic        gpif_dout_vld,
  output logic        gpif_eop,
  output logic        underrun
);

  localparam int unsigned     CntW    = cnt_width(BURST_WORDS);
  localparam logic [CntW-1:0] LastCnt = CntW'(BURST_WORDS - 1);

  gpif_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     dout_q;
  logic            vld_q;
  logic            eop_q;
  logic            underrun_q;

  logic window_open;
  logic beat;
  logic term;

  assign window_open = (state_q == StReady) || (state_q == StBurst);
  assign beat        = gpif_rd && window_open;
  // A pad beat (in_valid=0) can only end the burst on the length limit, never on in_eof.
  assign term        = beat && ((cnt_q == LastCnt) || (in_valid && in_eof));

  // Gated by reset so no upstream word is popped and then discarded.
  assign in_enable     = beat && in_valid && !gpif_rst;
  assign gpif_rdy      = window_open;
  assign gpif_dout     = dout_q;
  assign gpif_dout_vld = vld_q;
  assign gpif_eop      = eop_q;
  assign underrun      = underrun_q;

  always_ff @(posedge gpif_clk) begin
    if (gpif_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      eop_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      vld_q <= beat;
      eop_q <= term;
      if (beat) begin
        dout_q <= in_valid ? in_data : PAD_WORD;
      end

      if (beat && !in_valid) begin
        underrun_q <= 1'b1;
      end else if (clear) begin
        underrun_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (in_has_data) begin
            state_q <= StReady;
            cnt_q   <= '0;
          end
        end
        StReady, StBurst: begin
          if (beat) begin
            if (term) begin
              state_q <= StTurn;
            end else begin
              state_q <= StBurst;
              cnt_q   <= cnt_q + CntW'(1);
            end
          end
        end
        StTurn: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpif_burst_reader.sv
// Randomised and directed bench for gpif_burst_reader with a queue-based upstream model
// and a scoreboard checked by an independent output monitor.
module tb_gpif_burst_reader;

  localparam int unsigned BW  = 4;
  localparam logic [15:0] PAD = 16'h0000;

  logic        gpif_clk = 1'b0;
  logic        gpif_rst = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_eof = 1'b0;
  logic        in_has_data = 1'b0;
  logic        in_enable;
  logic        gpif_rd = 1'b0;
  logic        gpif_rdy;
  logic [15:0] gpif_dout;
  logic        gpif_dout_vld;
  logic        gpif_eop;
  logic        underrun;

  always #5 gpif_clk = ~gpif_clk;

  gpif_burst_reader #(
    .BURST_WORDS(BW),
    .PAD_WORD   (PAD)
  ) dut (
    .gpif_clk     (gpif_clk),
    .gpif_rst     (gpif_rst),
    .clear        (clear),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_eof       (in_eof),
    .in_has_data  (in_has_data),
    .in_enable    (in_enable),
    .gpif_rd      (gpif_rd),
    .gpif_rdy     (gpif_rdy),
    .gpif_dout    (gpif_dout),
    .gpif_dout_vld(gpif_dout_vld),
    .gpif_eop     (gpif_eop),
    .underrun     (underrun)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        eof;
  } word_t;

  typedef struct packed {
    logic [15:0] data;
    logic        eop;
  } exp_t;

  word_t src_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference model: host window (0 closed, 1 open, 2 turnaround), words sent this burst.
  int    m_phase = 0;
  int    m_words = 0;
  bit    m_und = 1'b0;
  bit    m_after_rst = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_words(input int n, input int eof_at);
    for (int i = 0; i < n; i++) begin
      src_q.push_back('{data: 16'($urandom_range(1, 16'hFFFF)), eof: (i == eof_at)});
    end
  endtask

  task automatic step(input bit rst, input bit has, input bit rd, input bit ven, input bit clr);
    bit    beat;
    bit    valid;
    bit    last;
    word_t w;
    @(negedge gpif_clk);
    chk("gpif_rdy", 32'(gpif_rdy), 32'(m_phase == 1));
    chk("underrun", 32'(underrun), 32'(m_und));
    if (m_after_rst) begin
      chk("rst_dout", 32'(gpif_dout), 32'd0);
      chk("rst_vld", 32'(gpif_dout_vld), 32'd0);
      chk("rst_eop", 32'(gpif_eop), 32'd0);
    end
    valid = ven && (src_q.size() > 0);
    // Junk on the bus when not valid, including a random eof that must be ignored.
    w = valid ? src_q[0] : '{data: 16'($urandom), eof: 1'($urandom)};
    gpif_rst    = rst;
    in_has_data = has;
    gpif_rd     = rd;
    clear       = clr;
    in_valid    = valid;
    in_data     = w.data;
    in_eof      = w.eof;
    beat = !rst && (m_phase == 1) && rd;
    #1;
    chk("in_enable", 32'(in_enable), 32'(beat && valid));
    if (rst) begin
      m_phase = 0;
      m_words = 0;
      m_und   = 1'b0;
    end else begin
      if (beat) begin
        last = (m_words == BW - 1) || (valid && w.eof);
        exp_q.push_back('{data: valid ? w.data : PAD, eop: last});
        if (valid) void'(src_q.pop_front());
        m_words++;
        if (last) m_phase = 2;
      end else if (m_phase == 0 && has) begin
        m_phase = 1;
        m_words = 0;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
      if (beat && !valid) m_und = 1'b1;
      else if (clr) m_und = 1'b0;
    end
    m_after_rst = rst;
  endtask

  // Output monitor: every valid word must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge gpif_clk);
      #2;
      if (gpif_dout_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("gpif_dout", 32'(gpif_dout), 32'(e.data));
          chk("gpif_eop", 32'(gpif_eop), 32'(e.eop));
        end
      end else begin
        chk("eop_without_vld", 32'(gpif_eop), 32'd0);
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Length-limited bursts with the host reading continuously.
    push_words(10, -1);
    repeat (16) step(0, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    src_q.delete();

    // Short packet terminated by in_eof, then no more data.
    push_words(3, 2);
    step(0, 1, 1, 1, 0);
    repeat (6) step(0, 0, 1, 1, 0);

    // Underrun: two real words then pads until the length limit.
    push_words(2, -1);
    step(0, 1, 1, 1, 0);
    repeat (6) step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1);

    // Host read strobe toggling.
    push_words(4, -1);
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, (i % 2) == 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);

    // Reset in the middle of a burst.
    push_words(8, -1);
    repeat (3) step(0, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    src_q.delete();

    // Clear coinciding with a pad beat, then clear alone.
    step(0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (4) step(0, 0, 1, 0, 0);

    repeat (400) begin
      if (src_q.size() < 4) push_words(6, ($urandom % 8 == 0) ? int'($urandom_range(0, 5)) : -1);
      step(($urandom % 60) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
           ($urandom % 5) != 0, ($urandom % 16) == 0);
    end

    repeat (4) step(0, 0, 0, 1, 0);
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
